// File: rtl/prob_sequencer.sv
// Sweeps the amplitude RAM through one shared qmult, emitting re^2+im^2 per index and the running norm.
// Build option PROB_SAT_EN: saturate magnitude additions on carry-out (default: wrap modulo 2^(N-1)).
module prob_sequencer #(
  parameter int Q        = 6,
  parameter int N        = 8,
  parameter int NUM_AMPS = 4,
  parameter int AW       = $clog2(NUM_AMPS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] amp_addr,
  input  logic [N-1:0]  amp_re,
  input  logic [N-1:0]  amp_im,
  output logic [N-1:0]  mul_a,
  output logic [N-1:0]  mul_b,
  input  logic [N-1:0]  mul_p,
  input  logic          mul_ovf,
  output logic          prob_valid,
  output logic [AW-1:0] prob_idx,
  output logic [N-1:0]  prob_out,
  output logic [N-1:0]  norm_out,
  output logic          ovf
);

  if (Q >= N || NUM_AMPS < 2 || (NUM_AMPS & (NUM_AMPS - 1)) != 0) begin : g_bad_params
    $error("prob_sequencer: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SQ_RE,
    S_SQ_IM,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [N-2:0]  MAG_MAX = '1;
  localparam logic [AW-1:0] LAST    = AW'(NUM_AMPS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  im_q;
  logic [N-2:0]  re2_q;
  logic [N-1:0]  prob_q;
  logic [AW-1:0] prob_idx_q;
  logic [N-1:0]  norm_q;
  logic          ovf_q;

  logic [N-2:0]  sq_mag;
  logic [N-1:0]  prob_sum;
  logic [N-2:0]  prob_mag;
  logic [N-1:0]  norm_sum;
  logic [N-2:0]  norm_mag;
  logic          unused_mul_sign;

  // Squares are non-negative by construction, so the product sign is discarded.
  assign unused_mul_sign = mul_p[N-1];
  assign sq_mag   = mul_ovf ? MAG_MAX : mul_p[N-2:0];
  assign prob_sum = {1'b0, re2_q} + {1'b0, sq_mag};
  assign norm_sum = {1'b0, norm_q[N-2:0]} + {1'b0, prob_mag};

`ifdef PROB_SAT_EN
  assign prob_mag = prob_sum[N-1] ? MAG_MAX : prob_sum[N-2:0];
  assign norm_mag = norm_sum[N-1] ? MAG_MAX : norm_sum[N-2:0];
`else
  assign prob_mag = prob_sum[N-2:0];
  assign norm_mag = norm_sum[N-2:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Strobes are gated by reset_n so a mid-sweep reset suppresses them in the same cycle.
  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    prob_valid = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    amp_addr   = addr_q;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        amp_addr  = idx;
        state_nxt = S_SQ_RE;
      end
      S_SQ_RE: begin
        mul_a     = amp_re;
        mul_b     = amp_re;
        state_nxt = S_SQ_IM;
      end
      S_SQ_IM: begin
        mul_a     = im_q;
        mul_b     = im_q;
        state_nxt = S_EMIT;
      end
      S_EMIT: begin
        prob_valid = reset_n;
        state_nxt  = (idx == LAST) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = reset_n;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx        <= '0;
      addr_q     <= '0;
      im_q       <= '0;
      re2_q      <= '0;
      prob_q     <= '0;
      prob_idx_q <= '0;
      norm_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            norm_q <= '0;
            ovf_q  <= 1'b0;
          end
        end
        S_FETCH: addr_q <= idx;
        S_SQ_RE: begin
          im_q  <= amp_im;
          re2_q <= sq_mag;
          if (mul_ovf) ovf_q <= 1'b1;
        end
        S_SQ_IM: begin
          prob_q     <= {1'b0, prob_mag};
          prob_idx_q <= idx;
          norm_q     <= {1'b0, norm_mag};
          if (mul_ovf || prob_sum[N-1] || norm_sum[N-1]) ovf_q <= 1'b1;
        end
        S_EMIT: if (idx != LAST) idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end

  assign prob_out = prob_q;
  assign prob_idx = prob_idx_q;
  assign norm_out = norm_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_prob_sequencer.sv
// Directed bench for prob_sequencer: registered-read RAM model, sign-magnitude qmult model, per-cycle checks.
module tb_prob_sequencer;
  localparam int Q  = 6;
  localparam int N  = 8;
  localparam int NA = 4;
  localparam int AW = 2;
  localparam int LAST_CYC = 4 * NA + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, prob_valid, ovf, mul_ovf;
  logic [AW-1:0] amp_addr, prob_idx;
  logic [N-1:0]  amp_re = '0, amp_im = '0;
  logic [N-1:0]  mul_a, mul_b, mul_p, prob_out, norm_out;

  logic [N-1:0]  ram_re [NA];
  logic [N-1:0]  ram_im [NA];
  logic [N-1:0]  exp_prob [NA];
  logic [N-1:0]  exp_norm [NA];
  logic          exp_ovf;

  int checks = 0;
  int failures = 0;

  prob_sequencer #(.Q(Q), .N(N), .NUM_AMPS(NA), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .amp_addr(amp_addr), .amp_re(amp_re), .amp_im(amp_im),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_ovf(mul_ovf),
    .prob_valid(prob_valid), .prob_idx(prob_idx), .prob_out(prob_out),
    .norm_out(norm_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    amp_re <= ram_re[amp_addr];
    amp_im <= ram_im[amp_addr];
  end

  logic [15:0] prod_full;
  logic [15:0] prod_mag;
  always_comb begin
    prod_full = 16'(mul_a[N-2:0]) * 16'(mul_b[N-2:0]);
    prod_mag  = prod_full >> Q;
    mul_ovf   = (prod_mag > 16'd127);
    mul_p     = {mul_a[N-1] ^ mul_b[N-1], prod_mag[N-2:0]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Caller sets start before calling; the next posedge is cycle 0 of the sweep.
  task automatic sweep(input string tag, input bit hold, input int ghost);
    int i;
    @(posedge clk);
    for (int c = 1; c <= LAST_CYC + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (ghost > 0 && c == ghost) start = 1'b1;
      if (ghost > 0 && c == ghost + 1) start = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 32'(c <= LAST_CYC));
      chk({tag, ".done"}, 32'(done), 32'(c == LAST_CYC));
      chk({tag, ".pvld"}, 32'(prob_valid), 32'((c % 4 == 0) && (c < LAST_CYC)));
      if (c == 1) begin
        chk({tag, ".ovf_clr"}, 32'(ovf), 32'd0);
        chk({tag, ".norm_clr"}, 32'(norm_out), 32'd0);
        chk({tag, ".addr0"}, 32'(amp_addr), 32'd0);
        chk({tag, ".mula_idle"}, 32'(mul_a), 32'd0);
      end
      if (c % 4 == 1 && c < LAST_CYC)
        chk({tag, ".addr"}, 32'(amp_addr), 32'((c - 1) / 4));
      if (c % 4 == 2 && c < LAST_CYC) begin
        i = (c - 2) / 4;
        chk({tag, ".mula_re"}, 32'(mul_a), 32'(ram_re[i]));
        chk({tag, ".mulb_re"}, 32'(mul_b), 32'(ram_re[i]));
      end
      if (c % 4 == 3 && c < LAST_CYC)
        chk({tag, ".mula_im"}, 32'(mul_a), 32'(ram_im[(c - 3) / 4]));
      if (c % 4 == 0 && c < LAST_CYC) begin
        i = c / 4 - 1;
        chk({tag, ".prob"}, 32'(prob_out), 32'(exp_prob[i]));
        chk({tag, ".pidx"}, 32'(prob_idx), 32'(i));
        chk({tag, ".norm"}, 32'(norm_out), 32'(exp_norm[i]));
      end
      if (c == LAST_CYC) begin
        chk({tag, ".ovf_end"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".norm_end"}, 32'(norm_out), 32'(exp_norm[NA-1]));
      end
    end
  endtask

  task automatic load_basis();
    ram_re   = '{8'h40, 8'h00, 8'h00, 8'h00};
    ram_im   = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_prob = '{8'h40, 8'h00, 8'h00, 8'h00};
    exp_norm = '{8'h40, 8'h40, 8'h40, 8'h40};
    exp_ovf  = 1'b0;
  endtask

  task automatic load_uniform();
    ram_re   = '{8'h20, 8'hA0, 8'h00, 8'h00};
    ram_im   = '{8'h00, 8'h00, 8'h20, 8'hA0};
    exp_prob = '{8'h10, 8'h10, 8'h10, 8'h10};
    exp_norm = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_ovf  = 1'b0;
  endtask

  initial begin
    load_basis();

    // Reset held with start high: everything stays at reset values.
    reset_n = 1'b0;
    start   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.pvld", 32'(prob_valid), 32'd0);
      chk("rst.norm", 32'(norm_out), 32'd0);
      chk("rst.prob", 32'(prob_out), 32'd0);
      chk("rst.pidx", 32'(prob_idx), 32'd0);
      chk("rst.ovf", 32'(ovf), 32'd0);
      chk("rst.addr", 32'(amp_addr), 32'd0);
      chk("rst.mula", 32'(mul_a), 32'd0);
      chk("rst.mulb", 32'(mul_b), 32'd0);
    end
    reset_n = 1'b1;
    sweep("basis", 1'b0, 0);

    load_uniform();
    start = 1'b1;
    sweep("uniform", 1'b0, 5);

    ram_re   = '{8'h40, 8'h40, 8'h40, 8'h40};
    ram_im   = '{8'h40, 8'h40, 8'h40, 8'h40};
`ifdef PROB_SAT_EN
    exp_prob = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    exp_norm = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
`else
    exp_prob = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_norm = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
    exp_ovf  = 1'b1;
    start = 1'b1;
    sweep("addovf", 1'b0, 0);

    // Multiplier overflow, then a back-to-back sweep that must clear ovf and norm.
    ram_re   = '{8'h7F, 8'h00, 8'h00, 8'h00};
    ram_im   = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_prob = '{8'h7F, 8'h00, 8'h00, 8'h00};
    exp_norm = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    exp_ovf  = 1'b1;
    start = 1'b1;
    sweep("mulovf", 1'b1, 0);
    load_basis();
    sweep("b2b", 1'b0, 0);

    // Reset asserted during the EMIT cycle of index 1.
    load_uniform();
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("mid.prob_pre", 32'(prob_out), 32'h10);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("mid.pvld", 32'(prob_valid), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.prob", 32'(prob_out), 32'd0);
    chk("mid.norm", 32'(norm_out), 32'd0);
    chk("mid.pidx", 32'(prob_idx), 32'd0);
    chk("mid.addr", 32'(amp_addr), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mid.no_done", 32'(done), 32'd0);
      chk("mid.idle", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prob_sequencer.md
# prob_sequencer

Controller that time-multiplexes one shared fixed-point multiplier across a stored state vector of complex amplitudes. For each basis index it computes the measurement probability re² + im², streams it out, and accumulates the total norm. It sits between the amplitude RAM and the shared qmult instance, and feeds the MicroBlaze GPIO and hex display path.

## Interface

Parameters:
- Q, 6, fractional bits of the sign-magnitude fixed-point format
- N, 8, total word width (MSB = sign, N-1 magnitude bits)
- NUM_AMPS, 4, number of amplitudes (2^qubits); must be a power of two ≥ 2
- AW, $clog2(NUM_AMPS), address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep end
- amp_addr  out  AW  amplitude RAM read address
- amp_re, amp_im  in  N  RAM read data; valid one cycle after amp_addr
- mul_a, mul_b  out  N  operands to the shared qmult
- mul_p  in  N  qmult product (combinational, same cycle)
- mul_ovf  in  1  qmult overflow
- prob_valid  out  1  one-cycle pulse, prob_out/prob_idx valid
- prob_idx  out  AW  basis index of prob_out
- prob_out  out  N  probability of prob_idx, sign bit always 0
- norm_out  out  N  running sum of probabilities; final when done
- ovf  out  1  sticky; cleared by reset or by an accepted start

## Operation

- States: IDLE, FETCH, SQ_RE, SQ_IM, EMIT, DONE.
- IDLE: if start, then clear norm_out, ovf and the index, and go to FETCH.
- FETCH: drive amp_addr = index, then go to SQ_RE.
- SQ_RE: latch amp_im into a register. Drive mul_a = mul_b = amp_re and register re2 = mul_p, then go to SQ_IM.
- SQ_IM: drive mul_a = mul_b = latched im. Register prob = re2 + mul_p (magnitude add) and norm_out += prob, then go to EMIT.
- EMIT: prob_valid = 1. If index == NUM_AMPS-1, go to DONE; otherwise increment the index and go to FETCH.
- DONE: done = 1, then go to IDLE.
- Squares: the sign is forced to 0. If mul_ovf is high in SQ_RE or SQ_IM, the product is replaced with the max magnitude (all-ones magnitude) and ovf is set.
- Addition overflow (carry out of the N-1 magnitude bits) is handled per Configuration, for both prob and norm.
- mul_a/mul_b are 0 outside SQ_RE and SQ_IM. amp_addr holds its last value outside FETCH.
- start while busy is ignored. There is no queuing.
- Reset mid-sweep: the block returns to IDLE and zeroes all outputs. No done pulse is produced.

## Timing

- Reset values: busy 0, done 0, amp_addr 0, mul_a/mul_b 0, prob_valid 0, prob_idx 0, prob_out 0, norm_out 0, ovf 0.
- Define cycle 0 as the edge at which start is sampled high in IDLE.
- FETCH for index i occupies cycle 1+4i. SQ_RE is 2+4i, SQ_IM is 3+4i, EMIT is 4+4i.
- prob_valid is high in cycle 4+4i. norm_out includes index i from that same cycle.
- done is high in cycle 4·NUM_AMPS+1 (cycle 17 at default parameters). busy falls in the following cycle.
- Back-to-back: start held high produces a new sweep with cycle 0 equal to the first IDLE cycle after DONE.
- prob_out, prob_idx and norm_out hold their values until the next accepted start or reset.

## Configuration

- PROB_SAT_EN defined: on addition overflow, the magnitude saturates to all ones (0x7F at N=8) and ovf is set.
- PROB_SAT_EN undefined: the magnitude wraps modulo 2^(N-1), the sign stays 0, and ovf is set.
- mul_ovf handling is identical in both builds.

## Test plan

- Reset: hold reset_n=0 with start=1 for 3 cycles -> all outputs stay at their reset values and busy=0. Release reset -> sweep starts at the next edge.
- Basis state: amps {(0x40,0),(0,0),(0,0),(0,0)} -> prob_out 0x40,0,0,0 on cycles 4/8/12/16 with idx 0..3. norm_out=0x40, done on cycle 17, ovf=0.
- Uniform and sign: amps (0x20,0x00),(0xA0,0x00),(0x00,0x20),(0x00,0xA0) -> every prob_out=0x10, norm_out=0x40. Checks that negative inputs square positive.
- Overflow: all amps (0x40,0x40) -> each sum is 0x80. With PROB_SAT_EN: prob_out=0x7F, norm_out=0x7F, ovf=1. Without: prob_out=0x00, ovf=1.
- Busy behaviour: pulse start at cycle 5 mid-sweep -> ignored, done still on cycle 17. Then assert reset_n=0 in the EMIT cycle of idx1 (cycle 8) of a new sweep -> no prob_valid that cycle, no done, IDLE next cycle.
- Back-to-back: start held high through two sweeps -> done on cycles 17 and 35. ovf and norm_out are cleared at the second start.
